// File: rtl/guess_judge_pkg.sv
// guess_pkg: shared state encoding, digit sizes and digit positions for the guess judge
//   no ports; imported by guess_judge_if, guess_digit_check and guess_judge
package guess_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int D_1 = 0;
  localparam int D_2 = 1;
  localparam int D_3 = 2;
  localparam int D_4 = 3;
  typedef enum logic [1:0] {IDLE, CHECK, SCAN, REPORT} state_e;
  typedef logic [DIGIT_W-1:0] digit_t;
endpackage

// File: rtl/guess_judge_if.sv
// guess_judge_if: request/result bundle between digit controller, judge and display
//   master drives start/new_game/q1..q4/a1..a4 and reads the results
//   slave (the judge) drives busy/done/count_a/count_b/invalid/win/attempts/game_over
interface guess_judge_if #(parameter int ATT_W = 4);
  import guess_pkg::*;
  logic start, new_game;
  digit_t q1, q2, q3, q4, a1, a2, a3, a4;
  logic busy, done, invalid, win, game_over;
  logic [2:0] count_a, count_b;
  logic [ATT_W-1:0] attempts;
  modport master (
    output start, new_game, q1, q2, q3, q4, a1, a2, a3, a4,
    input busy, done, count_a, count_b, invalid, win, attempts, game_over
  );
  modport slave (
    input start, new_game, q1, q2, q3, q4, a1, a2, a3, a4,
    output busy, done, count_a, count_b, invalid, win, attempts, game_over
  );
endinterface

// File: rtl/guess_judge_digit_check.sv
// guess_digit_check: flags a four-digit group holding a repeated digit or a digit above DIGIT_MAX
//   d   : the four digits, index 0 = rightmost position
//   bad : high when the group cannot be judged
module guess_digit_check import guess_pkg::*; #(
  parameter int DIGIT_MAX = 9
) (
  input  digit_t d [NUM_DIGITS],
  output logic   bad
);
  always_comb begin
    bad = 1'b0;
    for (int x = 0; x < NUM_DIGITS; x++) begin
      bad = bad | (d[x] > DIGIT_W'(DIGIT_MAX));
      for (int y = x + 1; y < NUM_DIGITS; y++)
        bad = bad | (d[x] == d[y]);
    end
  end
endmodule

// File: rtl/guess_judge.sv
// guess_judge: snapshots question/answer digits on start, validates them and scores xAyB over 16 pair compares
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/new_game and digits in; busy/done/counts/invalid/win/attempts/game_over out
module guess_judge import guess_pkg::*; #(
  parameter int MAX_ATTEMPTS = 10,
  parameter int ATT_W = 4,
  parameter int DIGIT_MAX = 9
) (
  input logic clock,
  input logic reset,
  guess_judge_if.slave bus
);
  state_e state_q, state_d;
  digit_t q_q [NUM_DIGITS], q_d [NUM_DIGITS], a_q [NUM_DIGITS], a_d [NUM_DIGITS];
  logic [3:0] idx_q, idx_d;
  logic [2:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d, count_a_q, count_a_d, count_b_q, count_b_d;
  logic bad_q, bad_d, invalid_q, invalid_d, win_q, win_d, over_q, over_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [ATT_W-1:0] att_q, att_d, att_inc;
  logic q_bad, a_bad, idle_free, hit;
  guess_digit_check #(.DIGIT_MAX(DIGIT_MAX)) u_q_check (.d(q_q), .bad(q_bad));
  guess_digit_check #(.DIGIT_MAX(DIGIT_MAX)) u_a_check (.d(a_q), .bad(a_bad));
  // idx_q walks the 16 pairs: upper bits pick the question digit, lower bits the answer digit
  assign hit = q_q[idx_q[3:2]] == a_q[idx_q[1:0]];
  // the done cycle is already IDLE but still busy, so requests wait one more cycle
  assign idle_free = state_q == IDLE && !busy_q;
  assign att_inc = att_q == ATT_W'(MAX_ATTEMPTS) ? att_q : att_q + 1'b1;
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    a_d = a_q;
    idx_d = idx_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    bad_d = bad_q;
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    invalid_d = invalid_q;
    win_d = win_q;
    over_d = over_q;
    att_d = att_q;
    busy_d = state_q != IDLE;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (idle_free && bus.new_game) begin
          att_d = '0;
          win_d = 1'b0;
          over_d = 1'b0;
        end else if (idle_free && bus.start && !over_q) begin
          q_d[D_1] = bus.q1;
          q_d[D_2] = bus.q2;
          q_d[D_3] = bus.q3;
          q_d[D_4] = bus.q4;
          a_d[D_1] = bus.a1;
          a_d[D_2] = bus.a2;
          a_d[D_3] = bus.a3;
          a_d[D_4] = bus.a4;
          acc_a_d = '0;
          acc_b_d = '0;
          idx_d = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        bad_d = q_bad | a_bad;
        idx_d = '0;
        state_d = bad_d ? REPORT : SCAN;
      end
      SCAN: begin
        acc_a_d = hit && idx_q[3:2] == idx_q[1:0] ? acc_a_q + 1'b1 : acc_a_q;
        acc_b_d = hit && idx_q[3:2] != idx_q[1:0] ? acc_b_q + 1'b1 : acc_b_q;
        idx_d = idx_q + 1'b1;
        state_d = idx_q == 4'd15 ? REPORT : SCAN;
      end
      REPORT: begin
        count_a_d = bad_q ? 3'd0 : acc_a_q;
        count_b_d = bad_q ? 3'd0 : acc_b_q;
        invalid_d = bad_q;
        att_d = bad_q ? att_q : att_inc;
        win_d = win_q | (!bad_q && acc_a_q == 3'd4);
        over_d = over_q | win_d | (att_d == ATT_W'(MAX_ATTEMPTS));
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      q_q <= '{default: '0};
      a_q <= '{default: '0};
      idx_q <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      bad_q <= 1'b0;
      count_a_q <= '0;
      count_b_q <= '0;
      invalid_q <= 1'b0;
      win_q <= 1'b0;
      over_q <= 1'b0;
      att_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      a_q <= a_d;
      idx_q <= idx_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      bad_q <= bad_d;
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
      invalid_q <= invalid_d;
      win_q <= win_d;
      over_q <= over_d;
      att_q <= att_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.count_a = count_a_q;
  assign bus.count_b = count_b_q;
  assign bus.invalid = invalid_q;
  assign bus.win = win_q;
  assign bus.attempts = att_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_guess_judge.sv
// tb_guess_judge: directed scenarios for guess_judge, checked every cycle against a bulls/cows model
module tb_guess_judge;
  localparam int MAXA = 10;
  localparam int AW = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0, fails = 0;
  guess_judge_if #(.ATT_W(AW)) bus ();
  guess_judge #(.MAX_ATTEMPTS(MAXA), .ATT_W(AW), .DIGIT_MAX(9)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // score from digit sets: bulls by position, cows = shared digits minus bulls
  function automatic void score(input logic [15:0] qv, input logic [15:0] av,
                                output logic ok, output int ba, output int cb);
    logic [15:0] qm, am;
    logic [3:0] qd, ad;
    qm = '0;
    am = '0;
    ba = 0;
    ok = 1'b1;
    for (int x = 0; x < 4; x++) begin
      qd = qv[4*x +: 4];
      ad = av[4*x +: 4];
      if (qd > 4'd9 || ad > 4'd9) ok = 1'b0;
      qm[qd] = 1'b1;
      am[ad] = 1'b1;
      if (qd == ad) ba++;
    end
    if ($countones(qm) != 4 || $countones(am) != 4) ok = 1'b0;
    cb = $countones(qm & am) - ba;
  endfunction
  int n = 0, acc_edge = -1000, lat = 0, p_a = 0, p_b = 0;
  int e_ca = 0, e_cb = 0, e_att = 0;
  logic p_ok = 1'b0, m_free;
  logic e_busy = 1'b0, e_done = 1'b0, e_inv = 1'b0, e_win = 1'b0, e_over = 1'b0;
  always @(posedge clock) begin
    n++;
    if (reset) begin
      acc_edge = -1000;
      e_ca = 0;
      e_cb = 0;
      e_inv = 1'b0;
      e_win = 1'b0;
      e_over = 1'b0;
      e_att = 0;
    end else begin
      if (n == acc_edge + lat) begin
        e_inv = !p_ok;
        e_ca = p_ok ? p_a : 0;
        e_cb = p_ok ? p_b : 0;
        if (p_ok) begin
          e_att = e_att < MAXA ? e_att + 1 : e_att;
          e_win = e_win || p_a == 4;
        end
        e_over = e_win || e_att == MAXA;
      end
      m_free = n >= acc_edge + lat + 2;
      if (m_free && bus.new_game) begin
        e_att = 0;
        e_win = 1'b0;
        e_over = 1'b0;
      end else if (m_free && bus.start && !e_over) begin
        acc_edge = n;
        score({bus.q4, bus.q3, bus.q2, bus.q1}, {bus.a4, bus.a3, bus.a2, bus.a1}, p_ok, p_a, p_b);
        lat = p_ok ? 18 : 2;
      end
    end
    e_done = n == acc_edge + lat;
    e_busy = n > acc_edge && n <= acc_edge + lat;
  end
  always @(negedge clock) begin
    if (n > 0) begin
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("count_a", bus.count_a, e_ca);
      chk("count_b", bus.count_b, e_cb);
      chk("invalid", bus.invalid, e_inv);
      chk("win", bus.win, e_win);
      chk("attempts", bus.attempts, e_att);
      chk("game_over", bus.game_over, e_over);
    end
  end
  task automatic set_qa(input logic [15:0] qv, input logic [15:0] av);
    {bus.q4, bus.q3, bus.q2, bus.q1} = qv;
    {bus.a4, bus.a3, bus.a2, bus.a1} = av;
  endtask
  // entered at a negedge; lat_o = edges from the start edge to done, -1 if no done
  task automatic run(input logic [15:0] qv, input logic [15:0] av, output int lat_o);
    set_qa(qv, av);
    bus.start = 1'b1;
    lat_o = -1;
    for (int m = 0; m < 40; m++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.done) begin
        lat_o = m;
        break;
      end
    end
    @(negedge clock);
  endtask
  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    @(negedge clock);
    bus.new_game = 1'b0;
    @(negedge clock);
  endtask
  int l, dones;
  initial begin
    bus.start = 1'b0;
    bus.new_game = 1'b0;
    set_qa(16'h0000, 16'h0000);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_attempts", bus.attempts, 0);
    @(negedge clock);
    run(16'h1234, 16'h1234, l);
    chk("win_latency", l, 18);
    chk("win_count_a", bus.count_a, 4);
    chk("win_flag", bus.win, 1);
    chk("win_game_over", bus.game_over, 1);
    chk("win_attempts", bus.attempts, 1);
    pulse_new_game();
    chk("ng_attempts", bus.attempts, 0);
    chk("ng_game_over", bus.game_over, 0);
    chk("ng_keeps_count_a", bus.count_a, 4);
    run(16'h1234, 16'h4321, l);
    chk("0a4b_a", bus.count_a, 0);
    chk("0a4b_b", bus.count_b, 4);
    run(16'h1234, 16'h1356, l);
    chk("1a1b_a", bus.count_a, 1);
    chk("1a1b_b", bus.count_b, 1);
    chk("1a1b_attempts", bus.attempts, 2);
    run(16'h1234, 16'h1123, l);
    chk("dup_latency", l, 2);
    chk("dup_invalid", bus.invalid, 1);
    chk("dup_attempts", bus.attempts, 2);
    run(16'h1234, 16'h112A, l);
    chk("dup_range_invalid", bus.invalid, 1);
    run(16'h1234, 16'h123A, l);
    chk("range_latency", l, 2);
    chk("range_invalid", bus.invalid, 1);
    for (int k = 0; k < 8; k++) run(16'h1234, 16'h5678, l);
    chk("max_attempts", bus.attempts, 10);
    chk("max_game_over", bus.game_over, 1);
    chk("max_invalid_cleared", bus.invalid, 0);
    run(16'h1234, 16'h1234, l);
    chk("over_no_done", l, -1);
    pulse_new_game();
    chk("restart_attempts", bus.attempts, 0);
    run(16'h1234, 16'h1243, l);
    chk("restart_latency", l, 18);
    chk("2a2b_a", bus.count_a, 2);
    chk("2a2b_b", bus.count_b, 2);
    set_qa(16'h1234, 16'h1235);
    bus.start = 1'b1;
    dones = 0;
    for (int m = 0; m < 40; m++) begin
      @(negedge clock);
      bus.start = m == 5;
      if (m == 6) set_qa(16'h1234, 16'h1234);
      if (bus.done) dones++;
    end
    chk("busy_start_dones", dones, 1);
    chk("snapshot_a", bus.count_a, 3);
    chk("snapshot_b", bus.count_b, 0);
    chk("snapshot_attempts", bus.attempts, 2);
    bus.start = 1'b1;
    bus.new_game = 1'b1;
    dones = 0;
    for (int m = 0; m < 25; m++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.new_game = 1'b0;
      if (bus.done || bus.busy) dones++;
    end
    chk("ng_start_no_scan", dones, 0);
    chk("ng_start_attempts", bus.attempts, 0);
    set_qa(16'h1234, 16'h5612);
    bus.start = 1'b1;
    for (int m = 0; m < 8; m++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_scan_busy", bus.busy, 0);
    chk("rst_scan_count_a", bus.count_a, 0);
    dones = 0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    chk("rst_scan_no_done", dones, 0);
    run(16'h1234, 16'h5612, l);
    chk("post_rst_latency", l, 18);
    chk("post_rst_b", bus.count_b, 2);
    chk("post_rst_attempts", bus.attempts, 1);
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
